// File: rtl/gamepad_cmd_decoder_if.sv
// Command handshake bundle between the gamepad decoder and the map consumer.
// master = decoder (drives the command), slave = consumer (drives ready).
interface gamepad_cmd_decoder_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;
    logic       cmd_dropped;

    modport master (output cmd_valid, output cmd_code, output cmd_dropped, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, input cmd_dropped, output cmd_ready);
endinterface

// File: rtl/gamepad_cmd_decoder.sv
// Gamepad command decoder: samples the pad once per v_sync frame, turns presses
// and auto-repeat into single cursor/edit commands on a valid/ready handshake,
// and owns the auto/manual robot mode and the robot step tick.
// Build option: define CMD_FIFO_EN to replace the single holding register with
// a 4-entry command FIFO. i_reset is asynchronous and active-low.
//
// state   | meaning
// ST_IDLE | no command held, cmd_valid low
// ST_PEND | command held in r_code, cmd_valid high until accepted
module gamepad_cmd_decoder #(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6,
    parameter int AUTO_PERIOD  = 25000000
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_v_sync,
    input  logic [11:0]                   i_gamepad_input,
    gamepad_cmd_decoder_if.master         cmd_if,
    output logic                          o_auto_mode,
    output logic                          o_robot_tick
);
    localparam logic [11:0] CMD_MASK = 12'h30F;
    localparam logic [2:0]  DIR_NONE = 3'd4;
    localparam int          REP_W    = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int          AUTO_W   = $clog2(AUTO_PERIOD);

    function automatic logic [2:0] lowest_dir(input logic [3:0] v);
        if (v[0]) return 3'd0;
        if (v[1]) return 3'd1;
        if (v[2]) return 3'd2;
        if (v[3]) return 3'd3;
        return DIR_NONE;
    endfunction

    logic              r_s1, r_s2, r_s3, r_eval;
    logic [11:0]       r_cur, r_prev;
    logic              w_frame_tick;
    logic [11:0]       w_press;
    logic [2:0]        w_press_code;
    logic [2:0]        w_held_dir;
    logic [2:0]        r_last_dir;
    logic [REP_W-1:0]  r_rep_cnt, w_rep_nxt;
    logic              w_rep_same, w_rep_fire;
    logic              w_event;
    logic [2:0]        w_ev_code;
    logic              w_toggle, w_step;
    logic              r_auto_mode, r_robot_tick;
    logic [AUTO_W-1:0] r_auto_cnt;

    assign w_frame_tick = r_s2 & ~r_s3;

    // v_sync synchroniser, frame sampling and one-cycle evaluate strobe.
    // Reset loads all-pressed so buttons held through reset do not count as presses.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_eval <= 1'b0;
            r_cur  <= 12'hFFF;
            r_prev <= 12'hFFF;
        end else begin
            r_s1   <= i_v_sync;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_eval <= w_frame_tick;
            if (w_frame_tick) begin
                r_cur  <= i_gamepad_input;
                r_prev <= r_cur;
            end
        end
    end

    // Press priority encode and auto-repeat cadence for the held direction.
    always_comb begin
        w_press      = r_cur & ~r_prev & CMD_MASK;
        w_press_code = 3'd0;
        if      (w_press[0]) w_press_code = 3'd1;
        else if (w_press[1]) w_press_code = 3'd2;
        else if (w_press[2]) w_press_code = 3'd3;
        else if (w_press[3]) w_press_code = 3'd4;
        else if (w_press[8]) w_press_code = 3'd5;
        else if (w_press[9]) w_press_code = 3'd6;
        w_held_dir = lowest_dir(r_cur[3:0] & r_prev[3:0]);
        w_rep_nxt  = r_rep_cnt + REP_W'(1);
        w_rep_same = (w_press_code == 3'd0) && (w_held_dir != DIR_NONE) && (w_held_dir == r_last_dir);
        w_rep_fire = r_eval && w_rep_same &&
                     ((w_rep_nxt == REP_W'(REPEAT_DELAY)) ||
                      (w_rep_nxt == REP_W'(REPEAT_DELAY + REPEAT_RATE)));
        w_event    = r_eval && ((w_press_code != 3'd0) || w_rep_fire);
        w_ev_code  = (w_press_code != 3'd0) ? w_press_code : (w_held_dir + 3'd1);
        w_toggle   = r_eval & r_cur[11] & ~r_prev[11];
        w_step     = r_eval & r_cur[10] & ~r_prev[10];
    end

    // Repeat counter: after the first repeat it parks at REPEAT_DELAY so the
    // following repeats land every REPEAT_RATE frames without a modulo.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rep_cnt  <= '0;
            r_last_dir <= 3'd0;
        end else if (r_eval) begin
            r_last_dir <= lowest_dir(r_cur[3:0]);
            if (!w_rep_same)
                r_rep_cnt <= '0;
            else if (w_rep_nxt == REP_W'(REPEAT_DELAY + REPEAT_RATE))
                r_rep_cnt <= REP_W'(REPEAT_DELAY);
            else
                r_rep_cnt <= w_rep_nxt;
        end
    end

    // Robot mode toggle, free-running auto step timer and manual step pulse.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_auto_mode  <= 1'b0;
            r_auto_cnt   <= '0;
            r_robot_tick <= 1'b0;
        end else if (w_toggle) begin
            r_auto_mode  <= ~r_auto_mode;
            r_auto_cnt   <= '0;
            r_robot_tick <= 1'b0;
        end else if (r_auto_mode) begin
            r_robot_tick <= (r_auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
            r_auto_cnt   <= (r_auto_cnt == AUTO_W'(AUTO_PERIOD - 1)) ? '0 : r_auto_cnt + AUTO_W'(1);
        end else begin
            r_robot_tick <= w_step;
        end
    end

    assign o_auto_mode  = r_auto_mode;
    assign o_robot_tick = r_robot_tick;

`ifdef CMD_FIFO_EN
    logic [2:0] r_mem [4];
    logic [1:0] r_wr, r_rd;
    logic [2:0] r_count;
    logic       r_drop;
    logic       w_pop, w_full, w_push;

    assign w_pop  = (r_count != 3'd0) && cmd_if.cmd_ready;
    assign w_full = (r_count == 3'd4);
    assign w_push = w_event && (!w_full || w_pop);

    // Command FIFO; a pop frees a slot for a push on the same edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 3'd0;
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_count <= 3'd0;
            r_drop  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_ev_code;
                r_wr        <= r_wr + 2'd1;
            end
            if (w_pop) r_rd <= r_rd + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            r_drop  <= w_event && w_full && !w_pop;
        end
    end

    assign cmd_if.cmd_valid   = (r_count != 3'd0);
    assign cmd_if.cmd_code    = (r_count != 3'd0) ? r_mem[r_rd] : 3'd0;
    assign cmd_if.cmd_dropped = r_drop;
`else
    typedef enum logic {ST_IDLE, ST_PEND} state_t;
    state_t     r_state, w_state_nxt;
    logic [2:0] r_code, w_code_nxt;
    logic       r_drop, w_drop_nxt;

    // Handshake state, held code and drop pulse registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_code  <= 3'd0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Next state: accept-and-reload on the same edge keeps the holding register full.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_drop_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_state_nxt = ST_PEND;
                    w_code_nxt  = w_ev_code;
                end
            end
            ST_PEND: begin
                if (w_event) begin
                    if (cmd_if.cmd_ready) w_code_nxt = w_ev_code;
                    else                  w_drop_nxt = 1'b1;
                end else if (cmd_if.cmd_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_code_nxt  = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = 3'd0;
            end
        endcase
    end

    assign cmd_if.cmd_valid   = (r_state == ST_PEND);
    assign cmd_if.cmd_code    = r_code;
    assign cmd_if.cmd_dropped = r_drop;
`endif
endmodule

// File: doc/gamepad_cmd_decoder.md
Name: gamepad_cmd_decoder

Overview:
- Upstream stage of the map/robot controller.
- Samples the 12-bit gamepad once per video frame on v_sync.
- Converts button presses and auto-repeat into single cursor/edit commands, delivered over a valid/ready handshake; cmd_ready is driven by the map's HabilitaNovaLeitura.
- Also owns auto/manual robot mode and generates the robot step-enable tick.

Parameters:
- REPEAT_DELAY, 20: frames a direction must be held before the first auto-repeat.
- REPEAT_RATE, 6: frames between subsequent auto-repeats.
- AUTO_PERIOD, 25000000: clock cycles between robot_tick pulses in auto mode. Minimum 2.

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- v_sync  in  1  asynchronous frame strobe.
- gamepad_input  in  12  button levels, 1 = pressed. [0] up, [1] down, [2] left, [3] right, [8] barrier, [9] trash, [10] manual step, [11] auto toggle; others ignored.
- cmd_ready  in  1  consumer can accept a command (HabilitaNovaLeitura).
- cmd_valid  out  1  command pending.
- cmd_code  out  3  1 up, 2 down, 3 left, 4 right, 5 barrier, 6 trash; 0 when idle.
- cmd_dropped  out  1  one-cycle pulse when an event is lost because the buffer is full.
- auto_mode  out  1  1 = robot runs from the internal timer.
- robot_tick  out  1  one-cycle robot step enable.

Behaviour:
- Reset values:
  - cmd_valid=0, cmd_code=0, cmd_dropped=0, auto_mode=0, robot_tick=0.
  - Sync flops s1/s2/s3=0, repeat counter=0, auto counter=0.
  - cur and prev = 12'hFFF, so buttons held through reset do not fire on release of reset.
- v_sync synchronisation:
  - v_sync passes through s1 -> s2; s3 delays s2.
  - frame_tick = s2 & ~s3.
- Frame sampling: on the edge where frame_tick=1, cur<=gamepad_input, prev<=cur, and eval<=1 for one cycle. gamepad_input must be stable on that edge.
- Event selection (on the edge where eval=1):
  - press = cur & ~prev, restricted to bits 0-3, 8, 9.
  - The lowest-index pressed bit becomes the event; other presses in that frame are discarded silently.
- Auto-repeat:
  - Applies only when no press occurs and the lowest-index held direction (cur & prev, bits 0-3) is unchanged from the last frame.
  - The per-frame repeat counter increments; an event fires when it reaches REPEAT_DELAY, then every REPEAT_RATE frames after that.
  - The counter clears when that held direction changes or is released.
- Latency: v_sync rising is sampled at edge 1, frame_tick is high after edge 2, cur is latched at edge 3, and cmd_valid is visible after edge 4.
- Handshake (states IDLE and PEND):
  - IDLE + event -> PEND: cmd_valid=1, cmd_code loaded.
  - PEND: cmd_code is held stable. When cmd_valid & cmd_ready on an edge, go to IDLE next cycle with cmd_code=0.
  - PEND + new event (not consumed the same edge) -> event dropped, cmd_dropped pulses one cycle.
  - Acceptance and a new event on the same edge -> the new event loads and the state stays PEND.
- Auto mode:
  - A press on bit 11 toggles auto_mode at the eval edge and clears the auto counter. It is never queued as a command.
  - In auto mode the counter runs 0..AUTO_PERIOD-1 and wraps; robot_tick pulses on the wrap cycle.
  - In manual mode a press on bit 10 pulses robot_tick for one cycle at the eval edge.
  - In auto mode, bit 10 is ignored.
- Reset mid-handshake: the pending command is lost; no pulse or tick is produced after reset.

Optional Feature:
- CMD_FIFO_EN defined: the single holding register is replaced by a 4-entry FIFO.
  - cmd_valid = FIFO not empty; cmd_code = head entry.
  - cmd_dropped pulses only on a push when the FIFO is full and not popping that same edge.
  - Simultaneous push and pop at full is allowed.
- CMD_FIFO_EN not defined: single-entry PEND behaviour as above.

Test Plan:
- Reset low with bit0 held, release reset, send a v_sync with bit0 still held -> no cmd_valid, because prev=FFF suppresses the press.
- Bit3 set, v_sync pulse, cmd_ready=0 -> cmd_valid=1, cmd_code=4 after edge 4 and held; cmd_ready=1 for one cycle -> cmd_valid=0 and cmd_code=0 on the next cycle.
- Bits 0 and 9 pressed in the same frame -> single command, code 1.
- cmd_ready=0, then press bit0 and bit1 in consecutive frames:
  - without CMD_FIFO_EN: code 1 pending, one cmd_dropped pulse;
  - with CMD_FIFO_EN: codes 1 then 2 delivered in order.
- REPEAT_DELAY=2, REPEAT_RATE=1, bit2 held for 6 frames, cmd_ready=1 -> code 3 events at frames 1, 3, 4, 5, 6.
- AUTO_PERIOD=5, press bit11 -> auto_mode=1 and robot_tick every 5 cycles; bit10 ignored. Press bit11 again -> auto_mode=0, ticks stop; bit10 press -> exactly one robot_tick.
